// File: rtl/spi_slave.sv
// SPI mode-0 target: oversampled SCK/MOSI/SS, byte deserialiser on MOSI and
// a one-entry transmit buffer feeding the MISO shifter.
module spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_spi_sck,
  input  logic       i_spi_mosi,
  input  logic       i_spi_ss,
  output logic       o_spi_miso,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx_underrun,
  output logic       o_busy
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_mosi_sync, r_ss_sync;
  logic       r_sck_d, r_ss_d;
  state_t     r_state, w_state_nxt;
  logic [7:0] r_tx_shift, r_rx_shift, r_rx_data, r_buf;
  logic [2:0] r_bit_cnt;
  logic       r_byte_done, r_buf_full, r_miso, r_rx_valid, r_tx_underrun;
  logic       w_sck, w_mosi, w_ss;
  logic       w_sck_rise, w_sck_fall, w_ss_fall, w_ss_rise;
  logic       w_load, w_write;
  logic [7:0] w_load_byte;

  // Presets match an idle bus so reset release never looks like an edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '1;
      r_ss_sync   <= '1;
      r_sck_d     <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_spi_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_spi_ss};
      r_sck_d     <= w_sck;
      r_ss_d      <= w_ss;
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss       = r_ss_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d & ~w_ss;
  assign w_sck_fall = ~w_sck & r_sck_d & ~w_ss;
  assign w_ss_fall  = ~w_ss & r_ss_d;
  assign w_ss_rise  = w_ss & ~r_ss_d;

  assign w_write     = i_tx_valid & ~r_buf_full;
  assign w_load_byte = r_buf_full ? r_buf : IDLE_BYTE;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt = S_ACTIVE;
          w_load      = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (w_ss_rise)                      w_state_nxt = S_IDLE;
        else if (w_sck_fall && r_byte_done) w_load      = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_buf         <= '0;
      r_bit_cnt     <= '0;
      r_byte_done   <= 1'b0;
      r_buf_full    <= 1'b0;
      r_miso        <= 1'b1;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      if (w_write) begin
        r_buf      <= i_tx_data;
        r_buf_full <= 1'b1;
      end
      // A load that coincides with a write sees an empty buffer; the written
      // byte stays parked for the next slot.
      if (w_state_nxt == S_IDLE) begin
        r_miso      <= 1'b1;
        r_bit_cnt   <= '0;
        r_byte_done <= 1'b0;
      end else if (w_load) begin
        r_tx_shift  <= w_load_byte;
        r_miso      <= w_load_byte[7];
        r_byte_done <= 1'b0;
        if (r_buf_full) r_buf_full    <= 1'b0;
        else            r_tx_underrun <= 1'b1;
      end else if (w_sck_fall) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        r_miso     <= r_tx_shift[6];
      end
      if (r_state == S_ACTIVE && w_sck_rise) begin
        r_rx_shift <= {r_rx_shift[6:0], w_mosi};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_rx_data   <= {r_rx_shift[6:0], w_mosi};
          r_rx_valid  <= 1'b1;
          r_byte_done <= 1'b1;
        end
      end
    end
  end

  assign o_spi_miso    = r_miso;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_tx_ready    = ~r_buf_full;
  assign o_tx_underrun = r_tx_underrun;
  assign o_busy        = ~w_ss;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master model at i_clk/8 plus a
// vector table of single-byte transfers and hand-written corner sequences.
module tb_spi_slave;

  logic       clk = 1'b0, rst = 1'b1;
  logic       sck = 1'b0, mosi = 1'b1, ss = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso, rx_valid, tx_ready, tx_underrun, busy;
  logic [7:0] rx_data;

  spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .i_clk(clk), .i_rst(rst), .i_spi_sck(sck), .i_spi_mosi(mosi),
    .i_spi_ss(ss), .o_spi_miso(miso), .o_rx_data(rx_data),
    .o_rx_valid(rx_valid), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready), .o_tx_underrun(tx_underrun), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int rxcnt = 0, unrcnt = 0;
  logic [7:0] rxlog [64];

  always @(negedge clk) begin
    if (rx_valid) begin
      rxlog[rxcnt % 64] = rx_data;
      rxcnt++;
    end
    if (tx_underrun) unrcnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge clk); tx_valid = 1'b1; tx_data = d;
    @(negedge clk); tx_valid = 1'b0;
  endtask

  task automatic ss_low;
    @(negedge clk); ss = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ss_high;
    repeat (4) @(negedge clk);
    ss = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Master byte: MOSI changes with SCK low, MISO sampled at the rising pin edge.
  task automatic xbyte(input logic [7:0] mb, input int nbits, output logic [7:0] sb,
                       output int lat, output int unr_snap);
    int rx0;
    sb = 8'h00; lat = 0; unr_snap = unrcnt;
    for (int i = 0; i < nbits; i++) begin
      mosi = mb[7-i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      sb[7-i] = miso;
      rx0 = rxcnt;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk); #1;
        if (lat == 0 && rxcnt != rx0) lat = k;
      end
      unr_snap = unrcnt;
      sck = 1'b0;
    end
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] txd;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_unr;
  } vec_t;

  vec_t vt [5];
  logic [7:0] sb, refill [3], bsent [3], bseen [3];
  int lat, us, rx0, u0, ridx;
  logic done;

  initial begin
    vt[0] = '{1'b1, 8'h3C, 8'hC3, 8'h3C, 8'hC3, 0};
    vt[1] = '{1'b0, 8'h00, 8'h40, 8'hFF, 8'h40, 1};
    vt[2] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E, 0};
    vt[3] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};
    vt[4] = '{1'b0, 8'h00, 8'hAA, 8'hFF, 8'hAA, 1};

    repeat (2) @(negedge clk);
    chk("rst_miso", miso, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      if (vt[v].wr) begin
        wr(vt[v].txd);
        chk($sformatf("v%0d_ready_low", v), tx_ready, 0);
      end
      rx0 = rxcnt; u0 = unrcnt;
      ss_low;
      chk($sformatf("v%0d_busy", v), busy, 1);
      chk($sformatf("v%0d_ready_back", v), tx_ready, 1);
      xbyte(vt[v].mosi, 8, sb, lat, us);
      chk($sformatf("v%0d_miso", v), sb, vt[v].exp_miso);
      chk($sformatf("v%0d_rx_data", v), rx_data, vt[v].exp_rx);
      chk($sformatf("v%0d_rx_pulses", v), rxcnt - rx0, 1);
      chk($sformatf("v%0d_latency_ok", v), (lat >= 1 && lat <= 4), 1);
      chk($sformatf("v%0d_underruns", v), us - u0, vt[v].exp_unr);
      ss_high;
      chk($sformatf("v%0d_busy_off", v), busy, 0);
    end

    // Reset in the middle of a transfer.
    wr(8'h55);
    ss_low;
    xbyte(8'hA5, 3, sb, lat, us);
    wr(8'h66);
    chk("mid_ready_low", tx_ready, 0);
    @(negedge clk); rst = 1'b1; #1;
    chk("mid_rst_miso", miso, 1);
    chk("mid_rst_rx_data", rx_data, 0);
    chk("mid_rst_rx_valid", rx_valid, 0);
    chk("mid_rst_ready", tx_ready, 1);
    chk("mid_rst_underrun", tx_underrun, 0);
    chk("mid_rst_busy", busy, 0);
    ss = 1'b1; sck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = rxcnt;
    ss_low;
    xbyte(8'hA5, 8, sb, lat, us);
    ss_high;
    chk("post_rst_rx_data", rx_data, 8'hA5);
    chk("post_rst_pulses", rxcnt - rx0, 1);
    chk("post_rst_miso", sb, 8'hFF);

    // Back-to-back burst with the buffer refilled whenever it is ready.
    refill[0] = 8'h10; refill[1] = 8'h20; refill[2] = 8'h30;
    bsent[0] = 8'h01; bsent[1] = 8'h02; bsent[2] = 8'h03;
    ridx = 0; done = 1'b0; rx0 = rxcnt;
    fork
      begin
        repeat (4) @(negedge clk);
        ss_low;
        for (int b = 0; b < 3; b++) begin
          xbyte(bsent[b], 8, sb, lat, us);
          bseen[b] = sb;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (tx_ready && ridx < 3) begin
            tx_valid = 1'b1; tx_data = refill[ridx]; ridx++;
          end else begin
            tx_valid = 1'b0;
          end
        end
        tx_valid = 1'b0;
      end
    join
    ss_high;
    chk("burst_pulses", rxcnt - rx0, 3);
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("burst%0d_miso", b), bseen[b], refill[b]);
      chk($sformatf("burst%0d_rx", b), rxlog[(rx0 + b) % 64], bsent[b]);
    end

    // Abort after five rises, then a clean byte.
    rx0 = rxcnt;
    ss_low;
    xbyte(8'hFF, 5, sb, lat, us);
    @(negedge clk); ss = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_no_pulse", rxcnt - rx0, 0);
    ss_low;
    xbyte(8'h5A, 8, sb, lat, us);
    ss_high;
    chk("abort_next_rx", rx_data, 8'h5A);
    chk("abort_next_pulses", rxcnt - rx0, 1);

    // Write while not ready must not overwrite the buffered byte.
    wr(8'h77);
    chk("ign_ready_low", tx_ready, 0);
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'hEE;
    @(negedge clk); tx_valid = 1'b0;
    chk("ign_still_full", tx_ready, 0);
    ss_low;
    xbyte(8'h00, 8, sb, lat, us);
    ss_high;
    chk("ign_miso_77", sb, 8'h77);
    ss_low;
    xbyte(8'h00, 8, sb, lat, us);
    ss_high;
    chk("ign_no_ee", sb, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI mode-0 target (responder) for the SoC's SD/SPI master interface: the other end of the link driven by o_spi_sck/o_spi_mosi/o_spi_ss.
- Oversamples SCK, MOSI and SS in the i_clk domain, deserialises MOSI bytes, and serialises response bytes on MISO from a one-entry transmit buffer.
- Used as a synthesizable SD-card/peripheral emulator and as the loopback target on the simulation bench.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each of SCK, MOSI and SS inputs (min 2)
IDLE_BYTE, 8'hFF, byte shifted out when the transmit buffer is empty

Ports:
i_clk  input  1  system clock; SCK frequency must be at most i_clk/8
i_rst  input  1  asynchronous active-high reset
i_spi_sck  input  1  SPI clock from master, CPOL=0
i_spi_mosi  input  1  master-out data
i_spi_ss  input  1  slave select, active low
o_spi_miso  output  1  slave-out data, registered
o_rx_data  output  8  last complete received byte
o_rx_valid  output  1  one-cycle pulse: o_rx_data updated
i_tx_data  input  8  next response byte
i_tx_valid  input  1  write strobe for i_tx_data
o_tx_ready  output  1  transmit buffer empty
o_tx_underrun  output  1  one-cycle pulse: IDLE_BYTE loaded instead of buffer data
o_busy  output  1  synchronised SS is asserted

Behaviour:
- Reset (async, i_rst=1): o_spi_miso=1, o_rx_data=8'h00, o_rx_valid=0, o_tx_ready=1, o_tx_underrun=0, o_busy=0. Shifters and bit counter clear, buffer empty, synchronisers preset to SCK=0, SS=1, MOSI=1.
- Edge detection: runs on the synchronised signals.
  - sck_rise = SCK 0->1 and ss_sync=0.
  - sck_fall = SCK 1->0 and ss_sync=0.
  - ss_fall and ss_rise are detected on ss_sync.
- State machine:
  - IDLE (SS high): o_spi_miso=1, bit_cnt=0.
  - On ss_fall go to ACTIVE. Load tx_shift from the buffer if full, clearing the buffer; otherwise load IDLE_BYTE and pulse o_tx_underrun. o_spi_miso takes tx_shift[7] on the following cycle.
  - ACTIVE, on sck_rise: rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt <= bit_cnt+1 (3-bit, wraps 7->0).
    - When the 8th rise completes (bit_cnt was 7): o_rx_data <= {rx_shift[6:0], mosi_sync}, pulse o_rx_valid the next cycle, set byte_done.
  - ACTIVE, on sck_fall:
    - If byte_done, load the next byte (buffer or IDLE_BYTE with underrun pulse), drive its MSB, and clear byte_done.
    - Otherwise tx_shift <= {tx_shift[6:0],1'b0} and drive the new MSB.
  - On ss_rise (from any point) go to IDLE. A partial byte is discarded with no o_rx_valid, and bit_cnt clears. A byte already loaded into tx_shift is consumed and not restored; the buffer contents are preserved.
- Latency: o_rx_valid is asserted within SYNC_STAGES+2 i_clk cycles of the 8th SCK rising edge at the pin.
- Buffer:
  - A write occurs when i_tx_valid and o_tx_ready are both high. i_tx_valid while not ready is ignored (no overwrite).
  - o_tx_ready falls the cycle after the write and rises the cycle after the shifter loads from the buffer.
  - Simultaneous write and load in the same cycle: the load sees the buffer as empty and sends IDLE_BYTE with underrun; the written byte remains buffered for the next byte slot.
- Back-to-back bytes: no gap is required between bytes. Continuous SCK yields one o_rx_valid per 8 edges.
- No receive backpressure: the consumer must take o_rx_data within 8 SCK periods.
- MSB first on both MOSI and MISO.

Test Plan:
- Reset mid-transfer: i_rst pulsed after 3 SCK rises -> all outputs at reset values immediately; the next full transfer of 8'hA5 yields o_rx_data=8'hA5 with one o_rx_valid pulse.
- Single byte: write i_tx_data=8'h3C, then SS low and master sends 8'hC3 at i_clk/8 -> master reads 8'h3C on MISO; o_rx_data=8'hC3; one o_rx_valid pulse; o_tx_ready returns to 1 after SS falls.
- Empty buffer: SS low with no prior tx write, master sends 8'h40 -> MISO carries 8'hFF, o_tx_underrun pulses once, o_rx_data=8'h40.
- Burst: master sends 8'h01,8'h02,8'h03 back-to-back while the bench refills the buffer with 8'h10,8'h20,8'h30 each time ready is high -> MISO carries 10,20,30; three o_rx_valid pulses carrying 01,02,03.
- Abort: SS rises after 5 SCK rises of 8'hFF -> no o_rx_valid, o_busy falls; the next full byte 8'h5A is received correctly.
- Ignored write: a second i_tx_valid while o_tx_ready=0 with 8'hEE -> the original buffered 8'h77 is transmitted; 8'hEE is never seen on MISO.
